// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command queue.
package alu_pkg;

    localparam int unsigned BUS_SIZE = 8;
    localparam int unsigned SHAMT_P  = 3;

    // ALU function encodings as presented on the select port.
    typedef enum logic [2:0] {
        OpAdd = 3'b000,
        OpSub = 3'b001,
        OpShl = 3'b010,
        OpShr = 3'b011,
        OpOr  = 3'b100,
        OpAnd = 3'b101,
        OpXor = 3'b110,
        OpNot = 3'b111
    } alu_op_e;

    // Bit positions inside the 4-bit {V,Z,N,C} flag vector.
    localparam int unsigned FLAG_V = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 0;

    typedef struct packed {
        logic [BUS_SIZE-1:0] a;
        logic [BUS_SIZE-1:0] b;
        alu_op_e             select;
        logic [SHAMT_P-1:0]  shamt;
    } alu_cmd_t;

    localparam int unsigned CMD_W = $bits(alu_cmd_t);

endpackage

// File: rtl/alu_cmd_queue_if.sv
// Upstream command, ALU-side and downstream result signals of the command queue.
interface alu_cmd_queue_if #(
    parameter int unsigned bus_size = 8,
    parameter int unsigned shamt_p  = 3,
    parameter int unsigned depth_p  = 2
);
    // Upstream command port
    logic                in_valid;
    logic                in_ready;
    logic [bus_size-1:0] in_a;
    logic [bus_size-1:0] in_b;
    logic [2:0]          in_select;
    logic [shamt_p-1:0]  in_shamt;
    // ALU side
    logic [bus_size-1:0] alu_a;
    logic [bus_size-1:0] alu_b;
    logic [2:0]          alu_select;
    logic [shamt_p-1:0]  alu_shamt;
    logic [bus_size-1:0] alu_s;
    logic [3:0]          alu_flags;
    // Downstream result port
    logic                res_valid;
    logic                res_ready;
    logic [bus_size-1:0] res_s;
    logic [3:0]          res_flags;
    logic [2:0]          res_select;
    // Status
    logic                sticky_v;
    logic                sticky_c;
    logic                clr_sticky;
    logic [depth_p:0]    count;

    // Environment side: producer, ALU and consumer.
    modport master (
        output in_valid, in_a, in_b, in_select, in_shamt, alu_s, alu_flags, res_ready,
               clr_sticky,
        input  in_ready, alu_a, alu_b, alu_select, alu_shamt, res_valid, res_s, res_flags,
               res_select, sticky_v, sticky_c, count
    );

    // Queue side.
    modport slave (
        input  in_valid, in_a, in_b, in_select, in_shamt, alu_s, alu_flags, res_ready,
               clr_sticky,
        output in_ready, alu_a, alu_b, alu_select, alu_shamt, res_valid, res_s, res_flags,
               res_select, sticky_v, sticky_c, count
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with 2^depth_p entries; caller never pushes when full or pops when empty.
module sync_fifo #(
    parameter int unsigned width   = 8,
    parameter int unsigned depth_p = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] wdata,
    output logic [width-1:0] rdata,
    output logic [depth_p:0] count,
    output logic             full,
    output logic             empty
);
    localparam int unsigned entries = 1 << depth_p;

    logic [width-1:0]   mem [entries];
    logic [depth_p-1:0] wr_ptr_q;
    logic [depth_p-1:0] rd_ptr_q;
    logic [depth_p:0]   count_q;
    logic [depth_p:0]   count_d;

    assign rdata = mem[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == (depth_p + 1)'(entries));
    assign empty = (count_q == '0);

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Occupancy next-state: simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally at their width.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/alu_cmd_queue.sv
// Command FIFO in front of an external ALU with a registered, handshaked result stage.
module alu_cmd_queue
    import alu_pkg::*;
#(
    parameter int unsigned bus_size = BUS_SIZE,
    parameter int unsigned shamt_p  = SHAMT_P,
    parameter int unsigned depth_p  = 2
) (
    input logic           clk,
    input logic           rst,
    alu_cmd_queue_if.slave bus
);
    alu_cmd_t            wr_cmd;
    alu_cmd_t            head_cmd;
    logic [CMD_W-1:0]    fifo_rdata;
    logic [depth_p:0]    fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                issue;

    logic                res_valid_q;
    logic [bus_size-1:0] res_s_q;
    logic [3:0]          res_flags_q;
    logic [2:0]          res_select_q;
    logic                sticky_v_q;
    logic                sticky_c_q;

    // Pack the offered command into the FIFO word.
    always_comb begin
        wr_cmd        = '0;
        wr_cmd.a      = bus.in_a;
        wr_cmd.b      = bus.in_b;
        wr_cmd.select = alu_op_e'(bus.in_select);
        wr_cmd.shamt  = bus.in_shamt;
    end

    // in_ready depends only on the registered occupancy.
    assign bus.in_ready = ~fifo_full;
    assign push         = bus.in_valid & ~fifo_full;
    assign issue        = ~fifo_empty & (~res_valid_q | bus.res_ready);

    sync_fifo #(
        .width   (CMD_W),
        .depth_p (depth_p)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (issue),
        .wdata (wr_cmd),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_cmd  = alu_cmd_t'(fifo_rdata);
    assign bus.count = fifo_count;

    // Present the FIFO head to the ALU; drive zeros when nothing is queued.
    always_comb begin
        bus.alu_a      = '0;
        bus.alu_b      = '0;
        bus.alu_select = '0;
        bus.alu_shamt  = '0;
        if (!fifo_empty) begin
            bus.alu_a      = head_cmd.a;
            bus.alu_b      = head_cmd.b;
            bus.alu_select = head_cmd.select;
            bus.alu_shamt  = head_cmd.shamt;
        end
    end

    // Result register: capture on issue, drop valid on a consume with nothing new behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q  <= 1'b0;
            res_s_q      <= '0;
            res_flags_q  <= '0;
            res_select_q <= '0;
        end else if (issue) begin
            res_valid_q  <= 1'b1;
            res_s_q      <= bus.alu_s;
            res_flags_q  <= bus.alu_flags;
            res_select_q <= bus.alu_select;
        end else if (res_valid_q && bus.res_ready) begin
            res_valid_q  <= 1'b0;
        end
    end

    // Sticky status: a captured V/C set overrides a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_v_q <= 1'b0;
            sticky_c_q <= 1'b0;
        end else begin
            sticky_v_q <= (sticky_v_q & ~bus.clr_sticky) | (issue & bus.alu_flags[FLAG_V]);
            sticky_c_q <= (sticky_c_q & ~bus.clr_sticky) | (issue & bus.alu_flags[FLAG_C]);
        end
    end

    assign bus.res_valid  = res_valid_q;
    assign bus.res_s      = res_s_q;
    assign bus.res_flags  = res_flags_q;
    assign bus.res_select = res_select_q;
    assign bus.sticky_v   = sticky_v_q;
    assign bus.sticky_c   = sticky_c_q;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed bench for alu_cmd_queue with a behavioural ALU closing the loop.
module tb_alu_cmd_queue;
    localparam int unsigned BW = 8;
    localparam int unsigned SW = 3;
    localparam int unsigned DP = 2;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    alu_cmd_queue_if #(.bus_size(BW), .shamt_p(SW), .depth_p(DP)) bus ();

    alu_cmd_queue #(.bus_size(BW), .shamt_p(SW), .depth_p(DP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference ALU: carry only for add/sub, sub carry means no borrow.
    always_comb begin
        logic [8:0] wide;
        logic [7:0] s;
        logic       v;
        logic       c;
        wide = '0;
        s    = '0;
        v    = 1'b0;
        c    = 1'b0;
        case (bus.alu_select)
            3'b000: begin
                wide = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                s    = wide[7:0];
                c    = wide[8];
                v    = (bus.alu_a[7] == bus.alu_b[7]) && (s[7] != bus.alu_a[7]);
            end
            3'b001: begin
                wide = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 9'd1;
                s    = wide[7:0];
                c    = wide[8];
                v    = (bus.alu_a[7] != bus.alu_b[7]) && (s[7] != bus.alu_a[7]);
            end
            3'b010:  s = bus.alu_a << bus.alu_shamt;
            3'b011:  s = bus.alu_a >> bus.alu_shamt;
            3'b100:  s = bus.alu_a | bus.alu_b;
            3'b101:  s = bus.alu_a & bus.alu_b;
            3'b110:  s = bus.alu_a ^ bus.alu_b;
            default: s = ~bus.alu_a;
        endcase
        bus.alu_s     = s;
        bus.alu_flags = {v, (s == 8'h00), s[7], c};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel,
                         input logic [2:0] sh);
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_select = sel;
        bus.in_shamt  = sh;
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_a       = '0;
        bus.in_b       = '0;
        bus.in_select  = '0;
        bus.in_shamt   = '0;
        bus.res_ready  = 1'b0;
        bus.clr_sticky = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_count", 32'(bus.count), 0);
        check("rst_res_valid", 32'(bus.res_valid), 0);
        check("rst_res_s", 32'(bus.res_s), 0);
        check("rst_res_flags", 32'(bus.res_flags), 0);
        check("rst_sticky", 32'({bus.sticky_v, bus.sticky_c}), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_alu_a_empty", 32'(bus.alu_a), 0);

        // 5 + 3: captured one edge after the push
        bus.res_ready = 1'b1;
        offer(8'h05, 8'h03, 3'b000, 3'd0);
        tick();
        bus.in_valid = 1'b0;
        check("add_count_after_push", 32'(bus.count), 1);
        check("add_not_yet_valid", 32'(bus.res_valid), 0);
        check("add_alu_a_head", 32'(bus.alu_a), 32'h05);
        tick();
        check("add_valid", 32'(bus.res_valid), 1);
        check("add_res_s", 32'(bus.res_s), 32'h08);
        check("add_flags", 32'(bus.res_flags), 32'h0);
        check("add_count_drained", 32'(bus.count), 0);
        tick();
        check("add_consumed", 32'(bus.res_valid), 0);

        // 7F + 01: signed overflow, sticky V until cleared
        offer(8'h7F, 8'h01, 3'b000, 3'd0);
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("ovf_res_s", 32'(bus.res_s), 32'h80);
        check("ovf_flags", 32'(bus.res_flags), 32'b1010);
        check("ovf_sticky_v", 32'(bus.sticky_v), 1);
        tick();
        check("ovf_sticky_holds", 32'(bus.sticky_v), 1);
        bus.clr_sticky = 1'b1;
        tick();
        bus.clr_sticky = 1'b0;
        check("ovf_sticky_cleared", 32'(bus.sticky_v), 0);

        // Five pushes with the consumer stalled: one captured, four queued
        bus.res_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            offer(8'(i), 8'h00, 3'b000, 3'd0);
            tick();
        end
        check("full_count", 32'(bus.count), 4);
        check("full_in_ready", 32'(bus.in_ready), 0);
        check("full_res_s_stable", 32'(bus.res_s), 1);
        check("full_res_valid", 32'(bus.res_valid), 1);
        // Push while full but issuing: must be rejected
        offer(8'h06, 8'h00, 3'b000, 3'd0);
        bus.res_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("full_push_rejected_count", 32'(bus.count), 3);
        check("drain_res_2", 32'(bus.res_s), 2);
        tick();
        check("drain_res_3", 32'(bus.res_s), 3);
        tick();
        check("drain_res_4", 32'(bus.res_s), 4);
        tick();
        check("drain_res_5", 32'(bus.res_s), 5);
        check("drain_count_0", 32'(bus.count), 0);
        tick();
        check("drain_done", 32'(bus.res_valid), 0);

        // Simultaneous push and issue at count=2
        bus.res_ready = 1'b0;
        offer(8'h10, 8'h00, 3'b000, 3'd0);
        tick();
        offer(8'h11, 8'h00, 3'b000, 3'd0);
        tick();
        offer(8'h12, 8'h00, 3'b000, 3'd0);
        tick();
        check("pp_count_before", 32'(bus.count), 2);
        offer(8'h13, 8'h00, 3'b000, 3'd0);
        bus.res_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("pp_count_same", 32'(bus.count), 2);
        check("pp_res_s", 32'(bus.res_s), 32'h11);
        tick();
        tick();
        check("pp_last_res", 32'(bus.res_s), 32'h13);
        tick();
        check("pp_drained", 32'({bus.res_valid, bus.count}), 0);

        // 3 - 3: zero with carry (no borrow)
        offer(8'h03, 8'h03, 3'b001, 3'd0);
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("sub_res_s", 32'(bus.res_s), 0);
        check("sub_flags", 32'(bus.res_flags), 32'b0101);
        check("sub_select", 32'(bus.res_select), 1);
        check("sub_sticky_c", 32'(bus.sticky_c), 1);

        // 81 << 1: carry masked for shifts
        offer(8'h81, 8'h00, 3'b010, 3'd1);
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("shl_res_s", 32'(bus.res_s), 32'h02);
        check("shl_flags", 32'(bus.res_flags), 32'b0000);
        check("shl_select", 32'(bus.res_select), 2);
        tick();

        // Reset with three queued commands and a pending result
        bus.res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(8'h20 + 8'(i), 8'h01, 3'b100, 3'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        check("prerst_count", 32'(bus.count), 3);
        check("prerst_valid", 32'(bus.res_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_count", 32'(bus.count), 0);
        check("midrst_valid", 32'(bus.res_valid), 0);
        check("midrst_sticky", 32'({bus.sticky_v, bus.sticky_c}), 0);
        check("midrst_in_ready", 32'(bus.in_ready), 1);
        check("midrst_res_s", 32'(bus.res_s), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_cmd_queue.md
Name: alu_cmd_queue

Overview:
- Command buffer and result capture stage wrapped around the combinational ALU.
  - Upstream side: accepts ALU operations (operands, select, shift amount) into a FIFO.
  - ALU side: presents the FIFO head on the ALU input ports and registers the ALU result and flags.
  - Downstream side: hands results to a consumer with a valid/ready handshake.
- Also keeps a sticky overflow/carry status for software polling.

Parameters:
- bus_size, 8, operand/result width; must equal 2^shamt_p.
- shamt_p, 3, shift-amount width.
- depth_p, 2, log2 of FIFO depth (default gives 4 entries).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a command is offered.
- in_ready  output  1  FIFO can accept a command (not full).
- in_a  input  bus_size  operand a.
- in_b  input  bus_size  operand b.
- in_select  input  3  ALU function: 000 add, 001 sub, 010 shl, 011 shr, 100 or, 101 and, 110 xor, 111 not.
- in_shamt  input  shamt_p  shift amount.
- alu_a  output  bus_size  FIFO head operand a, to ALU.
- alu_b  output  bus_size  FIFO head operand b, to ALU.
- alu_select  output  3  FIFO head select, to ALU.
- alu_shamt  output  shamt_p  FIFO head shamt, to ALU.
- alu_s  input  bus_size  ALU result.
- alu_flags  input  4  {overflow, zero, negative, carry_out} from ALU.
- res_valid  output  1  result register holds an unconsumed result.
- res_ready  input  1  consumer accepts the result.
- res_s  output  bus_size  registered result.
- res_flags  output  4  registered {V,Z,N,C}.
- res_select  output  3  select of the operation that produced res_s.
- sticky_v  output  1  set by any captured V=1.
- sticky_c  output  1  set by any captured C=1.
- clr_sticky  input  1  clears sticky_v and sticky_c.
- count  output  depth_p+1  FIFO occupancy.

Behaviour:
- Reset (rst=1 at an edge):
  - wr_ptr, rd_ptr and count clear to 0.
  - res_valid=0; res_s=0, res_flags=0, res_select=0.
  - sticky_v=0, sticky_c=0.
  - FIFO storage contents are don't-care.
  - Reset mid-operation discards all queued commands and any pending result.
- Combinational outputs:
  - in_ready = (count != 2^depth_p). It is independent of in_valid and of the downstream side.
  - alu_* = FIFO entry at rd_ptr whenever count>0; all zeros when empty.
- Push: when in_valid & in_ready, write {in_a, in_b, in_select, in_shamt} at wr_ptr, then wr_ptr+1 (wraps modulo 2^depth_p).
- Issue condition: issue = (count>0) & (~res_valid | res_ready).
- On issue:
  - res_s<=alu_s, res_flags<=alu_flags, res_select<=alu_select.
  - res_valid<=1; rd_ptr+1 with wrap.
- Consume without issue: if res_valid & res_ready & ~issue, then res_valid<=0.
- Result stability: while res_valid=1 and res_ready=0, res_* hold stable.
- Count update:
  - push & ~issue: count+1.
  - issue & ~push: count-1.
  - push & issue: count unchanged (simultaneous push/pop is legal at any non-full, non-empty occupancy).
- Full / empty:
  - Full: no push, even if the same cycle issues (in_ready is based on registered count only).
  - Empty: no issue; res_valid is governed only by consume.
- Latency and throughput:
  - A command pushed into an empty queue at edge t is captured at edge t+1; res_valid is high after edge t+1.
  - Steady-state throughput is 1 result/cycle when res_ready=1 continuously.
- Sticky flags:
  - On issue: sticky_v |= alu_flags[3]; sticky_c |= alu_flags[0].
  - clr_sticky clears both flags. If clr_sticky coincides with an issue carrying V/C=1, the set wins and the flag ends at 1.
- Protocol rule: in_valid held with changing data while in_ready=0 is legal; only the data present at the accepting edge is stored.

Decomposition:
- Package alu_pkg:
  - typedef alu_op_e (the eight select encodings).
  - Flag bit index constants FLAG_V=3, FLAG_Z=2, FLAG_N=1, FLAG_C=0.
  - Packed struct alu_cmd_t {a, b, select, shamt}, parameterised through bus_size/shamt_p localparams.
- Sub-module sync_fifo: width/depth-parameterised, with push/pop/count.
- Issue logic and the result register stay in alu_cmd_queue.
- The ALU itself is instantiated by the parent, not inside this block.

Test Plan:
- Reset, then push a=8'h05, b=8'h03, select=000, with res_ready=1 → res_valid high one edge after the push; res_s=8'h08; flags Z=0, N=0, C=0, V=0.
- Push 8'h7F+8'h01 (select 000) → res_s=8'h80, V=1, N=1; sticky_v=1 until clr_sticky is pulsed, then 0.
- Hold res_ready=0 and push 5 commands → the first is captured, 4 fill the FIFO, count=4, in_ready=0, res_s stable. Raise res_ready → results drain in order, one per cycle.
- Push and issue in the same cycle at count=2 → count stays 2; push at count=4 with an issue the same cycle → rejected (in_ready=0).
- Sub 8'h03-8'h03 (select 001) → res_s=0, Z=1, C=1. Shift-left a=8'h81, shamt=1 (select 010) → res_s=8'h02, C=0 (carry is masked for non-arithmetic operations).
- Assert rst with 3 queued commands and res_valid=1 → next cycle count=0, res_valid=0, sticky flags 0, in_ready=1.
